// File: rtl/uart_rx_word_if.sv
// rtl/uart_rx_word_if.sv - serial line and received-word strobe bundle for uart_rx_word
interface uart_rx_word_if;
  logic        i_Rx_Serial;
  logic        o_Rx_DV;
  logic [31:0] o_Rx_Word;
  logic        o_Rx_Busy;
  logic        o_Frame_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Word,
    input  o_Rx_Busy,
    input  o_Frame_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Word,
    output o_Rx_Busy,
    output o_Frame_Err
  );
endinterface

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 32-bit UART word receiver (start, 32 data LSB first, stop)
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_rx_word_if.slave  rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  state_t      state, state_n;
  logic [15:0] count, count_n;
  logic [4:0]  index, index_n;
  logic [31:0] shift, shift_n;
  logic [31:0] word, word_n;
  logic        dv, dv_n;
  logic        err, err_n;
  logic        r_Rx_meta, r_Rx;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_meta <= rx.i_Rx_Serial;
      r_Rx      <= r_Rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
      count <= '0;
      index <= '0;
      shift <= '0;
      word  <= '0;
      dv    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      index <= index_n;
      shift <= shift_n;
      word  <= word_n;
      dv    <= dv_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    index_n = index;
    shift_n = shift;
    word_n  = word;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        index_n = '0;
        if (!r_Rx) state_n = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high here was only a glitch
        if (count == HALF) begin
          count_n = '0;
          state_n = r_Rx ? IDLE : DATA;
        end else begin
          count_n = count + 16'd1;
        end
      end
      DATA: begin
        if (count == LAST) begin
          count_n        = '0;
          shift_n[index] = r_Rx;
          if (index == 5'd31) begin
            index_n = '0;
            state_n = STOP;
          end else begin
            index_n = index + 5'd1;
          end
        end else begin
          count_n = count + 16'd1;
        end
      end
      STOP: begin
        if (count == LAST) begin
          count_n = '0;
          state_n = CLEANUP;
          if (r_Rx) begin
            word_n = shift;
            dv_n   = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
        end else begin
          count_n = count + 16'd1;
        end
      end
      CLEANUP: begin
        // A held-low line (break) parks here instead of starting a new frame
        count_n = '0;
        if (r_Rx) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        index_n = '0;
      end
    endcase
  end

  assign rx.o_Rx_DV     = dv;
  assign rx.o_Rx_Word   = word;
  assign rx.o_Frame_Err = err;
  assign rx.o_Rx_Busy   = (state != IDLE);

endmodule
